// File: rtl/mod_data_mem_pkg.sv
// Shared definitions for the data memory responder: funct3 access encodings,
// the responder FSM state type and a size-decode helper.
package system_defines;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} dmem_size_e;

  // Access width from funct3; only the low two bits matter, and the
  // reserved codes (011/110/111) fall through to a full word.
  function automatic dmem_size_e size_of(input logic [2:0] f3);
    case (f3[1:0])
      F3_LB[1:0]: size_of = SZ_BYTE;
      F3_LH[1:0]: size_of = SZ_HALF;
      F3_LW[1:0]: size_of = SZ_WORD;
      default:    size_of = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mod_data_mem_if.sv
// Request/response bundle between the MEM stage (master) and the data
// memory responder (slave).
interface mod_data_mem_if;
  logic        mem_read_en_i;
  logic        mem_write_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        stall_o;
  logic        misaligned_o;

  modport master (
    output mem_read_en_i, mem_write_en_i, funct3_i, addr_i, wdata_i,
    input  rdata_o, ready_o, stall_o, misaligned_o
  );

  modport slave (
    input  mem_read_en_i, mem_write_en_i, funct3_i, addr_i, wdata_i,
    output rdata_o, ready_o, stall_o, misaligned_o
  );
endinterface

// File: rtl/mod_data_mem_align.sv
// Combinational lane logic for the data memory: byte enables and write-data
// lane shift for stores, lane select with sign/zero extension for loads.
// DMEM_MISALIGN_CHECK_EN: when defined, misaligned accesses are flagged and
// suppressed; otherwise they are aligned down and performed normally.
module mod_dmem_align
  import system_defines::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [31:0] eff_addr,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        misaligned
);

  dmem_size_e  size;
  logic [1:0]  lane;
  logic [31:0] shifted;
  logic        is_unsigned;

  assign size        = size_of(funct3);
  assign lane        = eff_addr[1:0];
  assign is_unsigned = (funct3 == F3_LBU) || (funct3 == F3_LHU);
  assign wdata_lane  = wdata << {lane, 3'b000};
  assign shifted     = mem_word >> {lane, 3'b000};

  // Effective address and misalignment flag.
  always_comb begin
    eff_addr   = addr;
    misaligned = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (size == SZ_HALF)      misaligned = addr[0];
    else if (size == SZ_WORD) misaligned = |addr[1:0];
`else
    if (size == SZ_HALF)      eff_addr[0]   = 1'b0;
    else if (size == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
  end

  // Store lane enables; a suppressed access writes nothing.
  always_comb begin
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
    if (misaligned) byte_en = 4'b0000;
  end

  // Load lane select and extension; a suppressed access returns zero.
  always_comb begin
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = mem_word;
    endcase
    if (misaligned) load_data = 32'h0;
  end

endmodule

// File: rtl/mod_data_mem.sv
// Data memory responder for the MEM stage: accepts one load/store, waits
// WAIT_STATES cycles, commits the access and pulses ready_o.
// DMEM_MISALIGN_CHECK_EN (in mod_dmem_align) selects misalignment trapping.
module mod_data_mem
  import system_defines::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  mod_data_mem_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_e state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_hold_reg, mem_word_reg;
  logic [2:0]  funct3_reg;
  logic        is_write_reg;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req, in_idle, commit;
  logic [31:0] cur_addr, cur_wdata, eff_addr, wdata_lane, load_data, resp_data;
  logic [2:0]  cur_funct3;
  logic        cur_write, misaligned;
  logic [3:0]  byte_en;
  logic [AW-1:0] idx;
  logic        unused_addr_bits;

  assign req     = bus.mem_read_en_i | bus.mem_write_en_i;
  assign in_idle = (state_reg == IDLE);

  // In IDLE the live request drives the lane logic (needed when there are no
  // wait states); afterwards the latched copy does.
  assign cur_addr   = in_idle ? bus.addr_i         : addr_reg;
  assign cur_wdata  = in_idle ? bus.wdata_i        : wdata_reg;
  assign cur_funct3 = in_idle ? bus.funct3_i       : funct3_reg;
  assign cur_write  = in_idle ? bus.mem_write_en_i : is_write_reg;

  mod_dmem_align u_align (
    .funct3     (cur_funct3),
    .addr       (cur_addr),
    .wdata      (cur_wdata),
    .mem_word   (mem_word_reg),
    .eff_addr   (eff_addr),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // Upper address bits wrap away; lane bits are consumed inside the aligner.
  assign idx              = eff_addr[AW+1:2];
  assign unused_addr_bits = ^{eff_addr[31:AW+2], eff_addr[1:0]};

  assign commit = ~rst_i & ((in_idle & req & (WAIT_STATES == 0)) |
                            ((state_reg == WAIT) & (cnt_reg == 4'd0)));

  assign resp_data        = is_write_reg ? 32'h0 : load_data;
  assign bus.ready_o      = (state_reg == RESP);
  assign bus.stall_o      = (in_idle & req) | (state_reg == WAIT);
  assign bus.misaligned_o = bus.ready_o & misaligned;
  assign bus.rdata_o      = bus.ready_o ? resp_data : rdata_hold_reg;

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, wait counter, request latches and held load data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      funct3_reg     <= 3'b000;
      is_write_reg   <= 1'b0;
      rdata_hold_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (in_idle && req) begin
        addr_reg     <= bus.addr_i;
        wdata_reg    <= bus.wdata_i;
        funct3_reg   <= bus.funct3_i;
        is_write_reg <= bus.mem_write_en_i;  // store wins over a simultaneous load
        cnt_reg      <= CNT_LOAD;
      end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (state_reg == RESP) rdata_hold_reg <= resp_data;
    end
  end

  // Memory array: lane-masked write and registered read on the commit edge.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      if (cur_write) begin
        for (int l = 0; l < 4; l++) begin
          if (byte_en[l]) mem[idx][8*l +: 8] <= wdata_lane[8*l +: 8];
        end
      end
      mem_word_reg <= mem[idx];
    end
  end

endmodule

// File: tb/tb_mod_data_mem.sv
// Bench for mod_data_mem: two instances (1 and 3 wait states) driven by
// directed and random accesses, checked against a byte-array memory model.
module tb_mod_data_mem;
  import system_defines::*;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   total = 0;
  int   bad   = 0;

  mod_data_mem_if b1 ();
  mod_data_mem_if b3 ();

  mod_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(b1));
  mod_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (.clk_i(clk), .rst_i(rst3), .bus(b3));

  always #5 clk = ~clk;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Byte-addressed reference memory per instance (4 KiB each).
  logic [7:0] mdl [2][4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s == 0) begin
      b1.mem_read_en_i = rd; b1.mem_write_en_i = wr; b1.funct3_i = f3;
      b1.addr_i = a; b1.wdata_i = wd;
    end else begin
      b3.mem_read_en_i = rd; b3.mem_write_en_i = wr; b3.funct3_i = f3;
      b3.addr_i = a; b3.wdata_i = wd;
    end
  endtask

  task automatic sample(input int s, output logic rdy, output logic stl, output logic mis,
                        output logic [31:0] rdat);
    if (s == 0) begin
      rdy = b1.ready_o; stl = b1.stall_o; mis = b1.misaligned_o; rdat = b1.rdata_o;
    end else begin
      rdy = b3.ready_o; stl = b3.stall_o; mis = b3.misaligned_o; rdat = b3.rdata_o;
    end
  endtask

  // Reference: access of n bytes at an address wrapped to 4 KiB, little-endian.
  task automatic model(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_mis);
    int n;
    int base;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    exp_mis = CHK && ((a % n) != 0);
    base = int'(a % 32'd4096);
    base = base - (base % n);
    exp_rd = 32'h0;
    if (!exp_mis) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mdl[s][base + i] = wd[8*i +: 8];
      end else if (rd) begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[s][base + i];
        if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
        if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
        exp_rd = v;
      end
    end
  endtask

  // One full request/response handshake with timing, flag and data checks.
  task automatic access(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] got, output logic got_mis);
    int ws;
    int cyc;
    bit done;
    logic rdy, stl, mis;
    logic [31:0] rdat, exp_rd;
    logic exp_mis;
    ws = (s == 0) ? 1 : 3;
    model(s, rd, wr, f3, a, wd, exp_rd, exp_mis);
    @(negedge clk);
    drive(s, rd, wr, f3, a, wd);
    #1;
    sample(s, rdy, stl, mis, rdat);
    check({tag, ":stall_c0"}, {31'b0, stl}, 32'd1);
    check({tag, ":ready_c0"}, {31'b0, rdy}, 32'd0);
    cyc = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      sample(s, rdy, stl, mis, rdat);
      if (rdy) done = 1;
      else check({tag, ":stall_wait"}, {31'b0, stl}, 32'd1);
    end
    check({tag, ":latency"}, 32'(cyc), 32'(ws + 1));
    check({tag, ":stall_resp"}, {31'b0, stl}, 32'd0);
    check({tag, ":misaligned"}, {31'b0, mis}, {31'b0, exp_mis});
    if ((rd && !wr) || exp_mis) check({tag, ":rdata"}, rdat, exp_rd);
    drive(s, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    got = rdat;
    got_mis = mis;
    $display("txn %s inst=%0d rd=%b wr=%b f3=%03b addr=0x%08h wdata=0x%08h rdata=0x%08h mis=%b lat=%0d",
             tag, s, rd, wr, f3, a, wd, rdat, mis, cyc);
  endtask

  initial begin
    logic [31:0] got, wd, a;
    logic gm, rdy, stl, mis, rd, wr;
    logic [2:0] f3;

    rst1 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, rdy, stl, mis, got);
      check("reset:ready", {31'b0, rdy}, 32'd0);
      check("reset:stall", {31'b0, stl}, 32'd0);
      check("reset:misaligned", {31'b0, mis}, 32'd0);
      check("reset:rdata", got, 32'h0);
    end

    // Word store then load.
    access(0, 1'b0, 1'b1, F3_LW, 32'h10, 32'hDEADBEEF, "sw_10", got, gm);
    access(0, 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, "lw_10", got, gm);
    check("lw_10:const", got, 32'hDEADBEEF);

    // Sub-word loads with extension.
    access(0, 1'b0, 1'b1, F3_LW, 32'h20, 32'h80FF7F01, "sw_20", got, gm);
    access(0, 1'b1, 1'b0, F3_LB, 32'h23, 32'h0, "lb_23", got, gm);
    check("lb_23:const", got, 32'hFFFFFF80);
    access(0, 1'b1, 1'b0, F3_LBU, 32'h23, 32'h0, "lbu_23", got, gm);
    check("lbu_23:const", got, 32'h00000080);
    access(0, 1'b1, 1'b0, F3_LH, 32'h22, 32'h0, "lh_22", got, gm);
    check("lh_22:const", got, 32'hFFFF80FF);
    access(0, 1'b1, 1'b0, F3_LHU, 32'h20, 32'h0, "lhu_20", got, gm);
    check("lhu_20:const", got, 32'h00007F01);

    // Partial stores.
    access(0, 1'b0, 1'b1, F3_LW, 32'h20, 32'h11223344, "sw_20b", got, gm);
    access(0, 1'b0, 1'b1, F3_LB, 32'h21, 32'h000000AA, "sb_21", got, gm);
    access(0, 1'b1, 1'b0, F3_LW, 32'h20, 32'h0, "lw_20a", got, gm);
    check("sb_21:const", got, 32'h1122AA44);
    access(0, 1'b0, 1'b1, F3_LH, 32'h22, 32'h0000BEEF, "sh_22", got, gm);
    access(0, 1'b1, 1'b0, F3_LW, 32'h20, 32'h0, "lw_20b", got, gm);
    check("sh_22:const", got, 32'hBEEFAA44);

    // Misaligned word store.
    access(0, 1'b0, 1'b1, F3_LW, 32'h10, 32'hCAFEF00D, "sw_10b", got, gm);
    access(0, 1'b0, 1'b1, F3_LW, 32'h13, 32'h12345678, "sw_13", got, gm);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("sw_13:mis_const", {31'b0, gm}, 32'd1);
    check("sw_13:rdata_const", got, 32'h0);
`else
    check("sw_13:mis_const", {31'b0, gm}, 32'd0);
`endif
    access(0, 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, "lw_10c", got, gm);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("sw_13:word_const", got, 32'hCAFEF00D);
`else
    check("sw_13:word_const", got, 32'h12345678);
`endif

    // Both enables: store wins; address aliasing.
    access(0, 1'b1, 1'b1, F3_LW, 32'h0, 32'h5, "rw_0", got, gm);
    access(0, 1'b1, 1'b0, F3_LW, 32'h0, 32'h0, "lw_0", got, gm);
    check("rw_0:const", got, 32'h5);
    access(0, 1'b1, 1'b0, F3_LW, 32'h1000, 32'h0, "lw_1000", got, gm);
    check("alias_1000:const", got, 32'h5);

    // Random traffic on a preloaded window, including aliased addresses.
    for (int i = 0; i < 16; i++)
      access(0, 1'b0, 1'b1, F3_LW, 32'h100 + 32'(4 * i), $urandom, "init", got, gm);
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = ~wr | 1'($urandom_range(0, 1));
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12);
      wd = $urandom;
      access(0, rd, wr, f3, a, wd, "rand", got, gm);
    end

    // Three wait states: normal access, then reset during the second WAIT cycle.
    access(1, 1'b0, 1'b1, F3_LW, 32'h40, 32'h600DF00D, "w3_sw_40", got, gm);
    access(1, 1'b1, 1'b0, F3_LH, 32'h42, 32'h0, "w3_lh_42", got, gm);
    check("w3_lh_42:const", got, 32'h0000600D);
    access(1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0, "w3_lw_40", got, gm);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, F3_LW, 32'h40, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    sample(1, rdy, stl, mis, got);
    check("abort:stall_before", {31'b0, stl}, 32'd1);
    rst3 = 1'b1;
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    sample(1, rdy, stl, mis, got);
    check("abort:ready", {31'b0, rdy}, 32'd0);
    check("abort:stall", {31'b0, stl}, 32'd0);
    check("abort:misaligned", {31'b0, mis}, 32'd0);
    check("abort:rdata", got, 32'h0);
    $display("txn abort inst=1 sw addr=0x00000040 reset in second wait cycle");
    @(negedge clk);
    rst3 = 1'b0;
    access(1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0, "w3_lw_40b", got, gm);
    check("abort:old_value", got, 32'h600DF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
